dualmem_port_master: RTL

- Initiator-side port driver for the 8K x 64 byte-enabled dual-port RAM (13-bit word address, 8 lane enables/write-enables).
- Converts a valid/ready request channel into RAM port strobes, captures the 1-cycle-latency read data, and returns responses on a valid/ready channel with a small buffer so rsp backpressure never loses data.
- One instance drives port A or port B of the RAM; two instances give independent masters.

---
 rtl/dualmem_pkg.sv | 13 +
 rtl/dualmem_rsp_fifo.sv | 56 +++++
 rtl/dualmem_port_master.sv | 84 ++++++++
 3 files changed

// File: rtl/dualmem_pkg.sv
// Shared widths and the response payload type for the dual-port RAM initiator.
package dualmem_pkg;

   localparam int unsigned DUALMEM_ADDR_W = 13;
   localparam int unsigned DUALMEM_DATA_W = 64;
   localparam int unsigned DUALMEM_BE_W   = 8;

   typedef struct packed {
      logic                      we;
      logic [DUALMEM_DATA_W-1:0] rdata;
   } dualmem_rsp_t;

endpackage

// File: rtl/dualmem_rsp_fifo.sv
// Response FIFO: circular buffer with pointers that wrap modulo DEPTH.
// A full FIFO accepts a push only when a pop happens in the same cycle.
module dualmem_rsp_fifo
   import dualmem_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         push,
   input  dualmem_rsp_t                 push_data,
   input  logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output dualmem_rsp_t                 head
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dualmem_rsp_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
      !(push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/dualmem_port_master.sv
// Initiator for one port of the 8K x 64 byte-enabled dual-port RAM. It turns a
// valid/ready request channel into RAM strobes and buffers the responses.
module dualmem_port_master
   import dualmem_pkg::*;
#(
   parameter int unsigned RSP_DEPTH = 3,
   parameter int unsigned ADDR_W    = DUALMEM_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [ADDR_W+2:0]         req_addr,
   input  logic [DUALMEM_BE_W-1:0]   req_be,
   input  logic [DUALMEM_DATA_W-1:0] req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_we,
   output logic [DUALMEM_DATA_W-1:0] rsp_rdata,
   output logic [DUALMEM_BE_W-1:0]   ram_en,
   output logic [DUALMEM_BE_W-1:0]   ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DUALMEM_DATA_W-1:0] ram_wdata,
   input  logic [DUALMEM_DATA_W-1:0] ram_rdata
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   logic             accept;
   logic             pending;
   logic             pending_we;
   logic [CNT_W-1:0] count;
   logic [OCC_W-1:0] occ;
   dualmem_rsp_t     push_data;
   dualmem_rsp_t     head;
   logic             unused_addr_lsb;

   // Credit counts the response still inside the RAM pipeline, so every
   // accepted request is guaranteed a FIFO slot. rsp_ready is deliberately
   // left out, which keeps it off the combinational path to req_ready.
   assign occ       = OCC_W'(count) + OCC_W'(pending);
   assign req_ready = rstn && (occ < OCC_W'(RSP_DEPTH));
   assign accept    = req_valid && req_ready;

   assign ram_en          = accept ? '1 : '0;
   assign ram_we          = (accept && req_we) ? req_be : '0;
   assign ram_addr        = req_addr[ADDR_W+2:3];
   assign ram_wdata       = req_wdata;
   assign unused_addr_lsb = ^req_addr[2:0];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pending    <= 1'b0;
         pending_we <= 1'b0;
      end else begin
         pending    <= accept;
         pending_we <= req_we;
      end
   end

   always_comb begin
      push_data.we    = pending_we;
      push_data.rdata = pending_we ? '0 : ram_rdata;
   end

   dualmem_rsp_fifo #(
      .DEPTH(RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (pending),
      .push_data (push_data),
      .pop       (rsp_valid && rsp_ready),
      .count     (count),
      .head      (head)
   );

   assign rsp_valid = rstn && (count != '0);
   assign rsp_we    = head.we;
   assign rsp_rdata = head.rdata;

endmodule
